// File: rtl/prog_fetch_unit.sv
// prog_fetch_unit: program RAM loader plus variable-length instruction fetch sequencer
module prog_fetch_unit #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MAX_BYTES = 3,
  parameter int LEN_W     = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_start,
  input  logic                          load_valid,
  input  logic [DATA_W-1:0]             load_data,
  input  logic                          load_last,
  output logic                          load_ready,
  output logic [ADDR_W:0]               load_count,
  output logic                          load_ovf,
  input  logic                          run_start,
  input  logic                          halt_req,
  input  logic                          jmp_en,
  input  logic [ADDR_W-1:0]             jmp_addr,
  output logic                          instr_valid,
  input  logic                          instr_ready,
  output logic [MAX_BYTES*DATA_W-1:0]   instr_bytes,
  output logic [LEN_W-1:0]              instr_len,
  output logic [ADDR_W-1:0]             instr_pc,
  output logic                          running,
  output logic                          halted
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [2:0] MAXB = 3'(MAX_BYTES);
  typedef enum logic [2:0] {IDLE, LOAD, FETCH, PRESENT, HALTED} state_t;
  state_t state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] pc, wr_addr, rd_addr;
  logic [2:0] cnt, op_len, cur_len, len_now;
  assign load_ready = state == LOAD;
  assign running = state == FETCH || state == PRESENT;
  assign halted = state == HALTED;
  // cnt = bytes already captured; rd_data holds byte cnt-1 of the instruction
  always_comb begin
    rd_addr = pc + ADDR_W'(cnt);
    op_len = {1'b0, rd_data[DATA_W-1 -: 2]} + 3'd1;
    cur_len = op_len > MAXB ? MAXB : op_len;
    len_now = cnt == 3'd1 ? cur_len : 3'(instr_len);
  end
  always_ff @(posedge clk) begin
    if (!rst && state == LOAD && load_valid) mem[wr_addr] <= load_data;
    rd_data <= mem[rd_addr];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc <= '0;
      wr_addr <= '0;
      cnt <= '0;
      load_count <= '0;
      load_ovf <= 1'b0;
      instr_valid <= 1'b0;
      instr_bytes <= '0;
      instr_len <= '0;
      instr_pc <= '0;
    end else begin
      case (state)
        IDLE, HALTED: begin
          if (load_start) begin
            state <= LOAD;
            wr_addr <= '0;
            pc <= '0;
            load_ovf <= 1'b0;
          end else if (run_start) begin
            state <= FETCH;
            cnt <= '0;
          end
        end
        LOAD: begin
          if (load_valid) begin
            wr_addr <= wr_addr + 1'b1;
            if (load_last) begin
              load_count <= (ADDR_W+1)'(wr_addr) + (ADDR_W+1)'(1);
              state <= IDLE;
            end else if (&wr_addr) begin
              load_ovf <= 1'b1;
              load_count <= (ADDR_W+1)'(DEPTH);
              state <= IDLE;
            end
          end
        end
        FETCH: begin
          if (cnt == 3'd1) begin
            instr_bytes <= (MAX_BYTES*DATA_W)'(rd_data);
            instr_len <= LEN_W'(cur_len);
            instr_pc <= pc;
          end else if (cnt != 3'd0) begin
            instr_bytes[(int'(cnt) - 1) * DATA_W +: DATA_W] <= rd_data;
          end
          if (cnt != 3'd0 && cnt == len_now) begin
            instr_valid <= 1'b1;
            state <= PRESENT;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        PRESENT: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            cnt <= '0;
            pc <= jmp_en ? jmp_addr : pc + ADDR_W'(instr_len);
            state <= halt_req ? HALTED : FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_prog_fetch_unit.sv
// tb_prog_fetch_unit: directed load/fetch/stall/jump/halt/overflow/reset checks
module tb_prog_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load_start = 1'b0, load_valid = 1'b0, load_last = 1'b0;
  logic [7:0] load_data = '0;
  logic load_ready, load_ovf;
  logic [8:0] load_count;
  logic run_start = 1'b0, halt_req = 1'b0, jmp_en = 1'b0, instr_ready = 1'b0;
  logic [7:0] jmp_addr = '0;
  logic instr_valid, running, halted;
  logic [23:0] instr_bytes;
  logic [1:0] instr_len;
  logic [7:0] instr_pc;
  int checks = 0;
  int fails = 0;

  prog_fetch_unit dut (
    .clk(clk), .rst(rst),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .load_count(load_count),
    .load_ovf(load_ovf), .run_start(run_start), .halt_req(halt_req),
    .jmp_en(jmp_en), .jmp_addr(jmp_addr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_bytes(instr_bytes), .instr_len(instr_len),
    .instr_pc(instr_pc), .running(running), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!instr_valid && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic chk_instr(input string tag, input int lat, input logic [23:0] b,
                           input logic [1:0] l, input logic [7:0] p);
    int n;
    wait_valid(n);
    chk({tag, " latency"}, 64'(n), 64'(lat));
    chk({tag, " bytes"}, 64'(instr_bytes), 64'(b));
    chk({tag, " len"}, 64'(instr_len), 64'(l));
    chk({tag, " pc"}, 64'(instr_pc), 64'(p));
  endtask

  task automatic handshake(input logic j, input logic [7:0] a, input logic h);
    instr_ready = 1'b1;
    jmp_en = j;
    jmp_addr = a;
    halt_req = h;
    step();
    instr_ready = 1'b0;
    jmp_en = 1'b0;
    halt_req = 1'b0;
  endtask

  task automatic load_byte(input logic [7:0] d, input logic last);
    load_valid = 1'b1;
    load_data = d;
    load_last = last;
    step();
    load_valid = 1'b0;
    load_last = 1'b0;
  endtask

  task automatic pulse_run();
    run_start = 1'b1;
    step();
    run_start = 1'b0;
  endtask

  task automatic pulse_load();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " valid"}, 64'(instr_valid), 64'd0);
    chk({tag, " bytes"}, 64'(instr_bytes), 64'd0);
    chk({tag, " len"}, 64'(instr_len), 64'd0);
    chk({tag, " pc"}, 64'(instr_pc), 64'd0);
    chk({tag, " running"}, 64'(running), 64'd0);
    chk({tag, " halted"}, 64'(halted), 64'd0);
    chk({tag, " load_ready"}, 64'(load_ready), 64'd0);
    chk({tag, " load_count"}, 64'(load_count), 64'd0);
    chk({tag, " load_ovf"}, 64'(load_ovf), 64'd0);
  endtask

  initial begin
    do_reset(2);
    chk_reset_state("reset0");
    // overflow load fills the whole RAM: 0x47,0x5A at 0..1, 0x41,0x99 at 0xFE..0xFF, zeros elsewhere
    pulse_load();
    chk("ovf load_ready", 64'(load_ready), 64'd1);
    for (int i = 0; i < 256; i++) begin
      if (i == 255) chk("ovf not yet", 64'(load_ovf), 64'd0);
      load_valid = 1'b1;
      load_data = i == 0 ? 8'h47 : i == 1 ? 8'h5A : i == 254 ? 8'h41 : i == 255 ? 8'h99 : 8'h00;
      step();
    end
    load_data = 8'hEE;
    chk("ovf flag", 64'(load_ovf), 64'd1);
    chk("ovf count", 64'(load_count), 64'd256);
    chk("ovf byte257 ready", 64'(load_ready), 64'd0);
    step();
    load_valid = 1'b0;
    chk("ovf count held", 64'(load_count), 64'd256);
    do_reset(2);
    chk_reset_state("reset1");
    pulse_run();
    chk_instr("ram kept", 3, 24'h005A47, 2'd2, 8'h00);
    do_reset(1);
    chk_reset_state("rst present");
    pulse_load();
    load_byte(8'h05, 1'b0);
    load_byte(8'h4A, 1'b0);
    do_reset(1);
    chk("rst load ready", 64'(load_ready), 64'd0);
    pulse_run();
    chk_instr("partial i0", 2, 24'h000005, 2'd1, 8'h00);
    handshake(1'b0, 8'h00, 1'b0);
    chk_instr("partial i1", 3, 24'h00004A, 2'd2, 8'h01);
    do_reset(1);
    pulse_load();
    load_byte(8'h05, 1'b0);
    load_byte(8'h4A, 1'b0);
    load_byte(8'h11, 1'b0);
    load_byte(8'h80, 1'b0);
    load_byte(8'h22, 1'b1);
    chk("load count", 64'(load_count), 64'd5);
    chk("load ovf", 64'(load_ovf), 64'd0);
    chk("load done ready", 64'(load_ready), 64'd0);
    pulse_run();
    chk("run running", 64'(running), 64'd1);
    chk_instr("prog i0", 2, 24'h000005, 2'd1, 8'h00);
    handshake(1'b0, 8'h00, 1'b0);
    chk_instr("prog i1", 3, 24'h00114A, 2'd2, 8'h01);
    handshake(1'b0, 8'h00, 1'b0);
    chk_instr("prog i2", 4, 24'h002280, 2'd3, 8'h03);
    for (int k = 0; k < 4; k++) begin
      jmp_en = k == 1;
      jmp_addr = 8'h10;
      halt_req = k == 2;
      step();
      chk("stall valid", 64'(instr_valid), 64'd1);
      chk("stall bytes", 64'(instr_bytes), 64'h002280);
      chk("stall len", 64'(instr_len), 64'd3);
      chk("stall pc", 64'(instr_pc), 64'h03);
    end
    jmp_en = 1'b0;
    halt_req = 1'b0;
    handshake(1'b0, 8'h00, 1'b0);
    chk("after stall halted", 64'(halted), 64'd0);
    chk_instr("prog i3", 2, 24'h000000, 2'd1, 8'h06);
    do_reset(1);
    pulse_run();
    chk_instr("jh i0", 2, 24'h000005, 2'd1, 8'h00);
    handshake(1'b1, 8'hFE, 1'b1);
    chk("jh halted", 64'(halted), 64'd1);
    chk("jh running", 64'(running), 64'd0);
    chk("jh valid", 64'(instr_valid), 64'd0);
    repeat (3) step();
    chk("jh still halted", 64'(halted), 64'd1);
    chk("jh still idle", 64'(instr_valid), 64'd0);
    pulse_run();
    chk("resume halted", 64'(halted), 64'd0);
    chk("resume running", 64'(running), 64'd1);
    chk_instr("wrap i0", 3, 24'h009941, 2'd2, 8'hFE);
    handshake(1'b0, 8'h00, 1'b0);
    chk_instr("wrap i1", 2, 24'h000005, 2'd1, 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
